// File: rtl/instr_encoder.sv
// Two-stage instruction encoder: S1 registers an accepted op, S2 encodes it into a 4-deep output FIFO.
// Define MUL_EN to make op 10 (mul) legal; without it op 10 is rejected like any unknown op.
module instr_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instr,
  output logic        err,
  output logic [15:0] instr_count,
  output logic [7:0]  err_count
);

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } req_t;

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] OPC_J   = 7'b1101111;
  localparam logic [6:0] OPC_B   = 7'b1100011;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  req_t        s1_q, s1_d;
  logic        s1_vld_q;
  logic [31:0] fifo_q [4];
  logic [1:0]  wr_ptr_q, rd_ptr_q;
  logic [2:0]  cnt_q, cnt_d;
  logic        err_q;
  logic [15:0] icnt_q, icnt_d;
  logic [7:0]  ecnt_q, ecnt_d;

  logic        accept, push, pop, illegal;
  logic [31:0] word;

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3, input req_t r);
    return {f7, r.rs2, r.rs1, f3, r.rd, OPC_R};
  endfunction

  function automatic logic [31:0] enc_i(input logic [2:0] f3, input req_t r);
    return {r.imm[11:0], r.rs1, f3, r.rd, OPC_I};
  endfunction

  function automatic logic [31:0] enc_sh(input logic [6:0] f7, input req_t r);
    return {f7, r.imm[4:0], r.rs1, 3'b101, r.rd, OPC_I};
  endfunction

  function automatic logic [31:0] enc_b(input logic [2:0] f3, input req_t r);
    return {r.imm[12], r.imm[10:5], r.rs2, r.rs1, f3, r.imm[4:1], r.imm[11], OPC_B};
  endfunction

  // Space is reserved for the op sitting in S1, so S2 can always push without stalling.
  assign in_ready  = (cnt_q + {2'b00, s1_vld_q}) < 3'd4;
  assign accept    = in_valid & in_ready;
  assign out_valid = (cnt_q != 3'd0);
  assign pop       = out_valid & out_ready;
  assign push      = s1_vld_q & ~illegal;
  assign instr     = out_valid ? fifo_q[rd_ptr_q] : 32'd0;
  assign err         = err_q;
  assign instr_count = icnt_q;
  assign err_count   = ecnt_q;

  always_comb begin
    word    = 32'd0;
    illegal = 1'b0;
    case (s1_q.op)
      6'd0:  word = enc_r(F7_ALT,  3'b000, s1_q);
      6'd1:  word = enc_r(F7_ZERO, 3'b000, s1_q);
      6'd2:  word = enc_r(F7_ZERO, 3'b111, s1_q);
      6'd3:  word = enc_r(F7_ZERO, 3'b110, s1_q);
      6'd4:  word = enc_r(F7_ZERO, 3'b100, s1_q);
      6'd5:  word = enc_r(F7_ZERO, 3'b010, s1_q);
      6'd6:  word = enc_r(F7_ZERO, 3'b011, s1_q);
      6'd7:  word = enc_r(F7_ALT,  3'b101, s1_q);
      6'd8:  word = enc_r(F7_ZERO, 3'b101, s1_q);
      6'd9:  word = enc_r(F7_ZERO, 3'b001, s1_q);
`ifdef MUL_EN
      6'd10: word = enc_r(F7_MUL,  3'b000, s1_q);
`else
      6'd10: illegal = 1'b1;
`endif
      6'd11: word = enc_i(3'b000, s1_q);
      6'd12: word = enc_i(3'b001, s1_q);
      6'd13: word = enc_i(3'b111, s1_q);
      6'd14: word = enc_i(3'b110, s1_q);
      6'd15: word = enc_i(3'b100, s1_q);
      6'd16: word = enc_i(3'b010, s1_q);
      6'd17: word = enc_i(3'b011, s1_q);
      6'd18: word = enc_sh(F7_ALT,  s1_q);
      6'd19: word = enc_sh(F7_ZERO, s1_q);
      6'd20: word = enc_sh(F7_MUL,  s1_q);
      6'd21: word = {s1_q.imm[31:12], s1_q.rd, 7'b0110111};
      6'd22: word = {s1_q.imm[31:12], s1_q.rd, 7'b0010111};
      6'd23: word = {s1_q.imm[11:0], s1_q.rs1, 3'b010, s1_q.rd, 7'b0000011};
      6'd24: word = {s1_q.imm[11:5], s1_q.rs2, s1_q.rs1, 3'b010, s1_q.imm[4:0], 7'b0100011};
      6'd25: word = {12'd0, s1_q.rs1, 8'd0, OPC_J};
      6'd26: begin
        // rd=0/imm=0 would be bit-identical to jr
        word    = {s1_q.imm[11:0], s1_q.rs1, 3'b000, s1_q.rd, OPC_J};
        illegal = (s1_q.rd == 5'd0) && (s1_q.imm[11:0] == 12'd0);
      end
      6'd27: begin
        word    = {s1_q.imm[20], s1_q.imm[10:1], s1_q.imm[11], s1_q.imm[19:12], s1_q.rd, OPC_J};
        illegal = (s1_q.imm[14:12] == 3'b000);
      end
      6'd28: word = enc_b(3'b000, s1_q);
      6'd29: word = enc_b(3'b001, s1_q);
      6'd30: word = enc_b(3'b100, s1_q);
      6'd31: word = enc_b(3'b101, s1_q);
      6'd32: word = enc_b(3'b110, s1_q);
      6'd33: word = enc_b(3'b111, s1_q);
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    s1_d   = accept ? '{op: op, rd: rd, rs1: rs1, rs2: rs2, imm: imm} : s1_q;
    cnt_d  = cnt_q + {2'b00, push} - {2'b00, pop};
    icnt_d = pop ? icnt_q + 16'd1 : icnt_q;
    ecnt_d = (s1_vld_q && illegal && ecnt_q != 8'hFF) ? ecnt_q + 8'd1 : ecnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q     <= '0;
      s1_vld_q <= 1'b0;
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      cnt_q    <= 3'd0;
      err_q    <= 1'b0;
      icnt_q   <= 16'd0;
      ecnt_q   <= 8'd0;
      for (int i = 0; i < 4; i++) fifo_q[i] <= 32'd0;
    end else begin
      s1_q     <= s1_d;
      s1_vld_q <= accept;
      cnt_q    <= cnt_d;
      err_q    <= s1_vld_q & illegal;
      icnt_q   <= icnt_d;
      ecnt_q   <= ecnt_d;
      if (push) begin
        fifo_q[wr_ptr_q] <= word;
        wr_ptr_q         <= wr_ptr_q + 2'd1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encodings, illegal ops, back-pressure, reset flush, err_count saturation.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [5:0]  op;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;
  logic        out_valid, out_ready;
  logic [31:0] instr;
  logic        err;
  logic [15:0] instr_count;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;
  int exp_icnt = 0;
  int exp_ecnt = 0;

  instr_encoder dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .instr(instr),
    .err(err), .instr_count(instr_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic send(input string tag, input logic [5:0] o, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [31:0] im);
    op = o; rd = d; rs1 = s1; rs2 = s2; imm = im;
    in_valid = 1'b1;
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic one(input string tag, input logic [5:0] o, input logic [4:0] d, input logic [4:0] s1,
                     input logic [4:0] s2, input logic [31:0] im, input logic [31:0] exp);
    out_ready = 1'b1;
    send(tag, o, d, s1, s2, im);
    chk({tag, "_lat"}, 32'(out_valid), 32'd0);
    tick();
    chk({tag, "_vld"}, 32'(out_valid), 32'd1);
    chk({tag, "_word"}, instr, exp);
    tick();
    exp_icnt++;
    chk({tag, "_icnt"}, 32'(instr_count), 32'(exp_icnt));
  endtask

  task automatic bad(input string tag, input logic [5:0] o, input logic [4:0] d, input logic [4:0] s1,
                     input logic [4:0] s2, input logic [31:0] im);
    out_ready = 1'b1;
    send(tag, o, d, s1, s2, im);
    tick();
    if (exp_ecnt < 255) exp_ecnt++;
    chk({tag, "_err"}, 32'(err), 32'd1);
    chk({tag, "_noout"}, 32'(out_valid), 32'd0);
    chk({tag, "_ecnt"}, 32'(err_count), 32'(exp_ecnt));
    tick();
    chk({tag, "_errpulse"}, 32'(err), 32'd0);
  endtask

  logic [31:0] burst_exp [4];
  int          acc, got;
  logic        rdy;

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_ovld",  32'(out_valid), 32'd0);
    chk("rst_err",   32'(err), 32'd0);
    chk("rst_icnt",  32'(instr_count), 32'd0);
    chk("rst_ecnt",  32'(err_count), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_rdy",   32'(in_ready), 32'd1);

    one("add",   6'd0,  5'd1, 5'd2, 5'd3, 32'd0,          32'h403100B3);
    one("sub",   6'd1,  5'd5, 5'd6, 5'd7, 32'd0,          32'h007302B3);
    one("addi",  6'd11, 5'd1, 5'd2, 5'd0, 32'h0000_07FF,  32'h7FF10093);
    one("srai",  6'd18, 5'd3, 5'd4, 5'd0, 32'd5,          32'h40525193);
    one("lui",   6'd21, 5'd2, 5'd0, 5'd0, 32'h1234_5000,  32'h12345137);
    one("sw",    6'd24, 5'd0, 5'd2, 5'd3, 32'd8,          32'h00312423);
    one("jr",    6'd25, 5'd0, 5'd1, 5'd0, 32'd0,          32'h0000806F);
    one("jalr",  6'd26, 5'd1, 5'd2, 5'd0, 32'd4,          32'h004100EF);
    one("jal",   6'd27, 5'd1, 5'd0, 5'd0, 32'h0000_3000,  32'h000030EF);
    bad("jal_alias",  6'd27, 5'd1, 5'd0, 5'd0, 32'h0000_0800);
    one("beq",   6'd28, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC,  32'hFE208EE3);
    bad("jalr_alias", 6'd26, 5'd0, 5'd0, 5'd0, 32'd0);
    bad("op40",       6'd40, 5'd1, 5'd1, 5'd1, 32'd0);

    // Back-pressure: hold out_ready low and offer six ops
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      op = 6'd0; rd = 5'(acc + 1); rs1 = 5'd1; rs2 = 5'd2; imm = '0;
      in_valid = 1'b1;
      rdy = in_ready;
      tick();
      if (rdy) acc++;
    end
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) burst_exp[k] = 32'h40208033 | (32'(k + 1) << 7);
    chk("bp_accepted", 32'(acc), 32'd4);
    chk("bp_rdy_low",  32'(in_ready), 32'd0);
    chk("bp_hold_vld", 32'(out_valid), 32'd1);
    chk("bp_hold_w0",  instr, burst_exp[0]);
    tick();
    chk("bp_stable",   instr, burst_exp[0]);
    out_ready = 1'b1;
    got = 0;
    for (int b = 0; b < 20 && got < 4; b++) begin
      if (out_valid) begin
        chk("bp_order", instr, burst_exp[got]);
        got++;
        exp_icnt++;
      end
      tick();
    end
    chk("bp_drained", 32'(got), 32'd4);
    chk("bp_icnt",    32'(instr_count), 32'(exp_icnt));
    chk("bp_empty",   32'(out_valid), 32'd0);

    // Reset with three words queued and a pop offered in the same cycle
    out_ready = 1'b0;
    send("q0", 6'd1, 5'd1, 5'd1, 5'd1, 32'd0);
    send("q1", 6'd1, 5'd2, 5'd1, 5'd1, 32'd0);
    send("q2", 6'd1, 5'd3, 5'd1, 5'd1, 32'd0);
    tick(); tick();
    chk("q_vld", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_icnt = 0; exp_ecnt = 0;
    chk("mr_ovld",  32'(out_valid), 32'd0);
    chk("mr_icnt",  32'(instr_count), 32'd0);
    chk("mr_ecnt",  32'(err_count), 32'd0);
    chk("mr_instr", instr, 32'd0);
    chk("mr_rdy",   32'(in_ready), 32'd1);
    tick();
    chk("mr_stay",  32'(out_valid), 32'd0);

`ifdef MUL_EN
    one("mul", 6'd10, 5'd1, 5'd2, 5'd3, 32'd0, 32'h023100B3);
`else
    bad("mul", 6'd10, 5'd1, 5'd2, 5'd3, 32'd0);
`endif

    // err_count saturation with back-to-back illegal ops
    out_ready = 1'b1;
    op = 6'd63; in_valid = 1'b1;
    for (int c = 0; c < 260; c++) tick();
    in_valid = 1'b0;
    tick(); tick();
    chk("sat_ecnt", 32'(err_count), 32'd255);
    chk("sat_noout", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Ports SHALL be: clk  in  1  sole clock, rising edge; reset  in  1  synchronous active-high reset.
REQ-002 Ports SHALL be: in_valid in 1; in_ready out 1; op in 6, alu_select-space opcode; rd, rs1, rs2 in 5 each; imm in 32.
REQ-003 Ports SHALL be: out_valid out 1; out_ready in 1; instr out 32, encoded word.
REQ-004 Ports SHALL be: err out 1, illegal-op pulse; instr_count out 16, words emitted; err_count out 8, rejected ops.
REQ-005 Reset SHALL be synchronous active-high on reset, sampled at the rising edge of clk, and clk SHALL be the only clock.

Function
REQ-006 Transfers SHALL occur when in_valid&&in_ready is high, or when out_valid&&out_ready is high, at a rising edge.
REQ-007 Stage S1 SHALL register each accepted op and its fields; stage S2 SHALL encode S1 and push the word into a 4-entry output FIFO.
REQ-008 Latency SHALL be 2 cycles from acceptance to out_valid with an empty FIFO; instr SHALL be the FIFO head.
REQ-009 in_ready SHALL be (fifo_count + s1_valid) < 4; no accepted op SHALL ever be dropped for lack of space.
REQ-010 R-type ops 0-10 SHALL encode as {f7,rs2,rs1,f3,rd,0110011}: add 0100000/000, sub 0000000/000, and /111, or /110, xor /100, slt /010, sltu /011, sra 0100000/101, srl 0000000/101, sll 0000000/001, mul 0000001/000.
REQ-011 Ops 11-17 (addi,subi,andi,ori,xori,slti,sltiu) SHALL encode as {imm[11:0],rs1,f3,rd,0010011} with f3 000,001,111,110,100,010,011.
REQ-012 Ops 18-20 (srai,srli,slli) SHALL encode as {f7,imm[4:0],rs1,101,rd,0010011} with f7 0100000, 0000000, 0000001.
REQ-013 lui 21 and auipc 22 SHALL encode as {imm[31:12],rd,opc}, with opc 0110111 and 0010111.
REQ-014 lw 23 SHALL encode as {imm[11:0],rs1,010,rd,0000011}; sw 24 SHALL encode as {imm[11:5],rs2,rs1,010,imm[4:0],0100011}.
REQ-015 jr 25 SHALL encode as {12'b0,rs1,8'b0,1101111}.
REQ-016 jalr 26 SHALL encode as {imm[11:0],rs1,000,rd,1101111}; rd==0 with imm[11:0]==0 SHALL be illegal because it aliases jr.
REQ-017 jal 27 SHALL encode as {imm[20],imm[10:1],imm[11],imm[19:12],rd,1101111}; imm[14:12]==000 SHALL be illegal because it aliases jalr.
REQ-018 Branches 28-33 (beq,bne,blt,bge,bltu,bgeu) SHALL encode as {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],1100011} with f3 000,001,100,101,110,111.
REQ-019 Ops 34-63, and any op marked illegal, SHALL push nothing, pulse err for one cycle in S2, and increment err_count, saturating at 255.
REQ-020 instr_count SHALL increment on each output transfer and wrap 65535->0.
REQ-021 A simultaneous FIFO push and pop SHALL leave fifo_count unchanged; a pop from an empty FIFO SHALL never occur.
REQ-022 out_valid SHALL remain high and instr SHALL remain stable while out_ready is low.

Reset
REQ-023 Reset SHALL clear S1 and the FIFO; out_valid, err, instr_count, err_count and instr SHALL reset to 0, and in_ready SHALL read 1 in the first cycle after reset.
REQ-024 Reset asserted mid-operation SHALL discard all in-flight and queued words with no output transfer in that cycle; reset SHALL take priority over any simultaneous handshake.

Configuration
REQ-025 With MUL_EN defined, op 10 SHALL encode per REQ-010; without MUL_EN, op 10 SHALL be illegal per REQ-019.

Verification
REQ-026 Scenario: op=0, rd=1, rs1=2, rs2=3, out_ready=1 -> instr=0x403100B3 two cycles after acceptance, and instr_count=1.
REQ-027 Scenario: op=27, imm=0x0000_3000, rd=1 -> instr=0x000030EF; then op=27, imm=0x0000_0800 -> err pulse, err_count=1, and no output word.
REQ-028 Scenario: out_ready=0 with 6 back-to-back ops -> exactly 4 accepted and in_ready=0; then out_ready=1 -> 4 words emitted in order.
REQ-029 Scenario: op=28, rs1=1, rs2=2, imm=-4 -> instr=0xFE208EE3; op=26, rd=0, imm=0 -> err pulse.
REQ-030 Scenario: reset asserted with 3 words queued -> out_valid=0 next cycle and both counters 0; op=10 without MUL_EN -> err pulse.
